// File: rtl/psum_requant_drain.sv
// Psum drain: adds bias, applies ReLU, requantizes (12,5) to (8,3) with rounding and saturation,
// then buffers results in a small FIFO toward activation writeback. Also counts saturation events.
module psum_requant_drain #(
  parameter int unsigned PSUM_DATA_SIZE = 12,
  parameter int unsigned PSUM_FRAC      = 5,
  parameter int unsigned ACT_DATA_SIZE  = 8,
  parameter int unsigned ACT_FRAC       = 3,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SAT_CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PSUM_DATA_SIZE-1:0] in_psum,
  input  logic [PSUM_DATA_SIZE-1:0] in_bias,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACT_DATA_SIZE-1:0]  out_act,
  input  logic                      sat_clr,
  output logic [SAT_CNT_W-1:0]      sat_count
);

  localparam int unsigned SH = PSUM_FRAC - ACT_FRAC;
  localparam int unsigned SW = PSUM_DATA_SIZE + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic signed [SW-1:0] B_MAX = SW'((2 ** (PSUM_DATA_SIZE - 1)) - 1);
  localparam logic signed [SW-1:0] B_MIN = ~B_MAX;
  localparam logic signed [SW-1:0] A_MAX = SW'((2 ** (ACT_DATA_SIZE - 1)) - 1);
  localparam logic signed [SW-1:0] A_MIN = ~A_MAX;
  localparam logic signed [SW-1:0] RND   = SW'(2 ** (SH - 1));

  logic                             s1_valid;
  logic signed [PSUM_DATA_SIZE-1:0] s1_b;
  logic                             s1_sat;
  logic                             s2_valid;
  logic [ACT_DATA_SIZE-1:0]         s2_act;
  logic                             s2_sat;

  logic [ACT_DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [CW-1:0]            count;

  logic                             in_fire_c;
  logic                             push_c;
  logic                             pop_c;
  logic [CW-1:0]                    occ_c;
  logic signed [SW-1:0]             sum_c;
  logic signed [PSUM_DATA_SIZE-1:0] bsat_c;
  logic                             s1_sat_c;
  logic signed [SW-1:0]             relu_c;
  logic signed [SW-1:0]             rnd_c;
  logic [ACT_DATA_SIZE-1:0]         act_c;
  logic                             s2_clamp_c;

  // Occupancy counts in-flight stages so accepted samples always have a FIFO slot.
  assign occ_c     = count + CW'(s1_valid) + CW'(s2_valid);
  assign in_ready  = (occ_c < CW'(FIFO_DEPTH));
  assign in_fire_c = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign out_act   = out_valid ? mem[rd_ptr] : '0;
  assign push_c    = s2_valid;
  assign pop_c     = out_valid && out_ready;

  // Bias add at one extra bit, clamped back to psum range.
  always_comb begin
    sum_c    = SW'($signed(in_psum)) + SW'($signed(in_bias));
    bsat_c   = sum_c[PSUM_DATA_SIZE-1:0];
    s1_sat_c = 1'b0;
    if (sum_c > B_MAX) begin
      bsat_c   = B_MAX[PSUM_DATA_SIZE-1:0];
      s1_sat_c = 1'b1;
    end else if (sum_c < B_MIN) begin
      bsat_c   = B_MIN[PSUM_DATA_SIZE-1:0];
      s1_sat_c = 1'b1;
    end
  end

  // ReLU, round half up, then narrow to activation range.
  always_comb begin
    relu_c = SW'(s1_b);
    if (relu_en && s1_b[PSUM_DATA_SIZE-1]) begin
      relu_c = '0;
    end
    rnd_c      = (relu_c + RND) >>> SH;
    act_c      = rnd_c[ACT_DATA_SIZE-1:0];
    s2_clamp_c = 1'b0;
    if (rnd_c > A_MAX) begin
      act_c      = A_MAX[ACT_DATA_SIZE-1:0];
      s2_clamp_c = 1'b1;
    end else if (rnd_c < A_MIN) begin
      act_c      = A_MIN[ACT_DATA_SIZE-1:0];
      s2_clamp_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_b     <= '0;
      s1_sat   <= 1'b0;
      s2_valid <= 1'b0;
      s2_act   <= '0;
      s2_sat   <= 1'b0;
    end else begin
      s1_valid <= in_fire_c;
      if (in_fire_c) begin
        s1_b   <= bsat_c;
        s1_sat <= s1_sat_c;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_act <= act_c;
        s2_sat <= s1_sat | s2_clamp_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= s2_act;
    end
  end

  // FIFO pointers and count; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_c && !pop_c) begin
        count <= count + CW'(1);
      end else if (!push_c && pop_c) begin
        count <= count - CW'(1);
      end
    end
  end

  // Sticky saturation counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (push_c && s2_sat && (sat_count != '1)) begin
      sat_count <= sat_count + SAT_CNT_W'(1);
    end
  end

endmodule
